pc_unit: RTL and testbench

//   Parametrised fetch-stage program counter, successor to the fixed 32-bit PC register.

---
 rtl/pc_unit_if.sv | 27 ++
 rtl/pc_unit.sv | 98 +++++++++
 tb/tb_pc_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Fetch-PC control/status bundle between the NPC/branch logic and pc_unit.
// The master drives the control-flow requests; the slave (pc_unit) returns the fetch address.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             en;
    logic             redir_valid;
    logic [WIDTH-1:0] redir_target;
    logic             exc_valid;
    logic             eret_valid;
    logic [WIDTH-1:0] eret_target;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             pc_valid;
    logic             pend_valid;
    logic             pc_misalign;

    modport master (
        output en, redir_valid, redir_target, exc_valid, eret_valid, eret_target,
        input  pc, pc_plus4, pc_valid, pend_valid, pc_misalign
    );

    modport slave (
        input  en, redir_valid, redir_target, exc_valid, eret_valid, eret_target,
        output pc, pc_plus4, pc_valid, pend_valid, pc_misalign
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential stepping, exception vector / return and
// branch redirect in fixed priority, with a one-deep buffer for redirects seen while stalled.
// Optional macro PC_ALIGN_CHK_EN: when defined, targets load unmodified and pc_misalign
// reports |pc[1:0]; when undefined, target bits [1:0] are cleared and pc_misalign is 0.
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_4180),
    parameter int unsigned      STEP      = 4
) (
    input logic       clk,
    input logic       reset,
    pc_unit_if.slave  bus
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;

    function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] a);
`ifdef PC_ALIGN_CHK_EN
        return a;
`else
        return {a[WIDTH-1:2], 2'b00};
`endif
    endfunction

    // Next-state / next-PC selection in priority order: exc, eret, redirect, pending, step, stall.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end else if (bus.exc_valid) begin
            pc_d    = EXC_VEC;
            pend_d  = '0;
            state_d = ST_RUN;
        end else if (bus.eret_valid) begin
            pc_d    = align(bus.eret_target);
            pend_d  = '0;
            state_d = ST_RUN;
        end else if (bus.en && bus.redir_valid) begin
            pc_d    = align(bus.redir_target);
            pend_d  = '0;
            state_d = ST_RUN;
        end else if (bus.en && state_q == ST_PEND) begin
            pc_d    = pend_q;
            pend_d  = '0;
            state_d = ST_RUN;
        end else if (bus.en) begin
            pc_d    = pc_q + WIDTH'(STEP);
        end else if (bus.redir_valid) begin
            pend_d  = align(bus.redir_target);
            state_d = ST_PEND;
        end
    end

    // State, PC and pending-target registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VEC;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    logic misalign_q;

    // Misalignment flag registered alongside the PC it describes.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= |pc_d[1:0];
        end
    end

    assign bus.pc_misalign = misalign_q;
`else
    assign bus.pc_misalign = 1'b0;
`endif

    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_q + WIDTH'(STEP);
    assign bus.pc_valid   = (state_q != ST_BOOT);
    assign bus.pend_valid = (state_q == ST_PEND);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized control-flow traffic
// checked every cycle against a rule-level reference model.
module tb_pc_unit;

    logic clk = 1'b0;
    logic reset;

    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit #(
        .WIDTH    (32),
        .RESET_VEC(32'h0000_3000),
        .EXC_VEC  (32'h0000_4180),
        .STEP     (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model state.
    logic [31:0] m_pc      = 32'h0;
    bit          m_booting = 1'b1;
    bit          m_pending = 1'b0;
    logic [31:0] m_target  = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] tgt(input logic [31:0] a);
`ifdef PC_ALIGN_CHK_EN
        return a;
`else
        return a & 32'hFFFF_FFFC;
`endif
    endfunction

    function automatic logic model_misalign();
`ifdef PC_ALIGN_CHK_EN
        return (m_pc % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Apply the rules for one clock edge using the inputs currently on the bus.
    task automatic model_edge();
        if (reset) begin
            m_pc = 32'h0000_3000; m_booting = 1; m_pending = 0; m_target = 0;
        end else if (m_booting) begin
            m_booting = 0;
        end else if (bus.exc_valid) begin
            m_pc = 32'h0000_4180; m_pending = 0;
        end else if (bus.eret_valid) begin
            m_pc = tgt(bus.eret_target); m_pending = 0;
        end else if (bus.en && bus.redir_valid) begin
            m_pc = tgt(bus.redir_target); m_pending = 0;
        end else if (bus.en && m_pending) begin
            m_pc = m_target; m_pending = 0;
        end else if (bus.en) begin
            m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        end else if (bus.redir_valid) begin
            m_pending = 1; m_target = tgt(bus.redir_target);
        end
    endtask

    // One cycle: edge, model update, then compare all outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("pc", bus.pc, m_pc);
        check("pc_plus4", bus.pc_plus4, 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000));
        check("pc_valid", 32'(bus.pc_valid), 32'(!m_booting));
        check("pend_valid", 32'(bus.pend_valid), 32'(m_pending));
        check("pc_misalign", 32'(bus.pc_misalign), 32'(model_misalign()));
    endtask

    task automatic drive(input bit r, input bit e, input bit rv, input logic [31:0] rt,
                         input bit xv, input bit ev, input logic [31:0] et);
        reset = r; bus.en = e; bus.redir_valid = rv; bus.redir_target = rt;
        bus.exc_valid = xv; bus.eret_valid = ev; bus.eret_target = et;
    endtask

    initial begin
        drive(1, 1, 0, 0, 0, 0, 0);
        #2;
        // Reset then three enabled cycles.
        step();
        check("t1_reset_pc", bus.pc, 32'h3000);
        check("t1_reset_valid", 32'(bus.pc_valid), 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        step(); check("t1_boot", bus.pc, 32'h3000);
        check("t1_valid", 32'(bus.pc_valid), 1);
        step(); check("t1_step1", bus.pc, 32'h3004);
        step(); check("t1_step2", bus.pc, 32'h3008);

        // Stalled redirect is buffered and applied on resume.
        drive(0, 1, 1, 32'h3010, 0, 0, 0); step(); check("t2_pc0", bus.pc, 32'h3010);
        drive(0, 0, 1, 32'h3400, 0, 0, 0); step(); check("t2_hold", bus.pc, 32'h3010);
        check("t2_pend", 32'(bus.pend_valid), 1);
        drive(0, 1, 0, 0, 0, 0, 0);        step(); check("t2_apply", bus.pc, 32'h3400);
        check("t2_pend_clr", 32'(bus.pend_valid), 0);

        // Exception overrides a pending redirect even while stalled.
        drive(0, 0, 1, 32'h3400, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 0, 0);        step(); check("t3_exc", bus.pc, 32'h4180);
        check("t3_pend_clr", 32'(bus.pend_valid), 0);
        drive(0, 1, 0, 0, 0, 0, 0);        step(); check("t3_next", bus.pc, 32'h4184);

        // exc beats eret beats redirect.
        drive(0, 1, 1, 32'h3500, 1, 1, 32'h3020); step(); check("t4_prio", bus.pc, 32'h4180);
        drive(0, 1, 1, 32'h3500, 0, 1, 32'h3020); step(); check("t4_eret", bus.pc, 32'h3020);

        // Wrap at the top of the address space.
        drive(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0); step();
        drive(0, 1, 0, 0, 0, 0, 0);             step(); check("t5_wrap", bus.pc, 32'h0);

        // Misaligned target handling.
        drive(0, 1, 1, 32'h3402, 0, 0, 0); step();
`ifdef PC_ALIGN_CHK_EN
        check("t6_pc", bus.pc, 32'h3402); check("t6_mis", 32'(bus.pc_misalign), 1);
`else
        check("t6_pc", bus.pc, 32'h3400); check("t6_mis", 32'(bus.pc_misalign), 0);
`endif

        // Reset during PEND discards the buffered redirect.
        drive(0, 0, 1, 32'h3600, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0, 0);        step(); check("rst_pend", 32'(bus.pend_valid), 0);
        drive(0, 1, 0, 0, 0, 0, 0);        step();
        step(); check("rst_pend_lost", bus.pc, 32'h3004);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rt, et;
            rt = $urandom;
            et = $urandom;
            if ($urandom_range(0, 3) == 0) rt = 32'hFFFF_FFF0 | (rt & 32'hF);
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) == 0, rt, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 11) == 0, et);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
